// File: rtl/pipe_dmem_responder.sv
// Multi-cycle data-memory responder for the M stage: services one load/store after LATENCY cycles.
// Optional misaligned word-access trap: define DMEM_MISALIGN_TRAP_EN.
module pipe_dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        we_sb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]        state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              we_reg, sb_reg;
    logic [31:0]       addr_reg, wdata_reg;
    logic              ready_reg, err_reg, load_ok_reg;
    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic [31:0]       mem_q;

    logic              c_we, c_sb;
    logic [31:0]       c_addr, c_wdata;
    logic              commit, oor, misalign, bad, is_store;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        be;
    logic [31:0]       wr_word;

    // With LATENCY==1 the commit edge is the acceptance edge, so live inputs are used then.
    assign c_we    = (state_reg == IDLE) ? we    : we_reg;
    assign c_sb    = (state_reg == IDLE) ? we_sb : sb_reg;
    assign c_addr  = (state_reg == IDLE) ? addr  : addr_reg;
    assign c_wdata = (state_reg == IDLE) ? wdata : wdata_reg;

    assign commit = req & (((state_reg == IDLE) && (LATENCY == 1)) ||
                           ((state_reg == WAIT) && (cnt_reg == 4'd1)));

    assign oor      = |c_addr[31:ADDR_W+2];
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ~c_sb & (c_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign bad      = oor | misalign;
    assign is_store = c_we | c_sb;
    assign idx      = c_addr[ADDR_W+1:2];

    // Byte store hits only lane addr[1:0]; word store hits all lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign be[gi] = commit & ~bad & (c_sb ? (c_addr[1:0] == 2'(gi)) : c_we);
            assign wr_word[gi*8 +: 8] = c_sb ? c_wdata[7:0] : c_wdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[idx][b*8 +: 8] <= wr_word[b*8 +: 8];
            end
        end
        if (commit) begin
            mem_q <= mem[idx];
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    cnt_next   = LAT_M1;
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    // Pipeline flush: drop the request silently.
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_next = RESP;
                    end
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            we_reg      <= 1'b0;
            sb_reg      <= 1'b0;
            addr_reg    <= 32'd0;
            wdata_reg   <= 32'd0;
            ready_reg   <= 1'b0;
            err_reg     <= 1'b0;
            load_ok_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if ((state_reg == IDLE) && req) begin
                we_reg    <= we;
                sb_reg    <= we_sb;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
            ready_reg   <= commit;
            err_reg     <= commit & bad;
            load_ok_reg <= commit & ~bad & ~is_store;
        end
    end

    // Gating by load_ok_reg makes rdata zero outside a good load's ready cycle and clears it on reset.
    assign rdata = load_ok_reg ? mem_q : 32'd0;
    assign ready = ready_reg;
    assign err   = err_reg;
    assign stall = req & ~ready_reg;

endmodule
